sar_scan_ctrl: RTL
==================

# sar_scan_ctrl

Conversion sequencer for the 8-bit SAR ADC core (`sar_logic`). It scans up to NCH analog channels round-robin and drives the channel-select mux. For each conversion it waits a settling time, pulses `cnvst`, waits for `eoc` and captures `sar`. Each result goes out on a valid/ready port tagged with its channel, with a timeout error flag.

## Interface
- NCH, 4: number of channels (2..16)
- CHW, 2: channel index width, equal to clog2(NCH)
- DW, 8: result width, matches `sar`
- SETTLE, 4: mux settling cycles before `cnvst` (≥1)
- CNV_PULSE, 2: `cnvst` high width in cycles (≥1)
- TIMEOUT, 64: maximum cycles to wait for `eoc` (≥16)

Ports:
- clk  in  1  single clock shared with `sar_logic`
- rst  in  1  synchronous, active-high reset
- en  in  1  scanning enable (level)
- ch_mask  in  NCH  enabled channels; bit i = channel i
- ch_sel  out  CHW  analog mux select
- cnvst  out  1  conversion start, to `sar_logic`
- eoc  in  1  end of conversion, from `sar_logic`
- sar  in  DW  conversion result, from `sar_logic`
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts
- res_data  out  DW  captured result
- res_ch  out  CHW  channel of `res_data`
- res_err  out  1  result produced by timeout; `res_data` is 0
- busy  out  1  high whenever the state is not IDLE

## Operation
- FSM states: IDLE, SETTLE, START, CONV, HOLD.
- IDLE to SETTLE:
  - Taken when en=1 and ch_mask≠0.
  - `ch_sel` ← next set bit in ch_mask strictly after `last_ch`, wrapping around.
  - `last_ch` resets to NCH-1, so the first conversion is the lowest enabled channel.
  - ch_mask=0 → remain in IDLE.
- SETTLE: count SETTLE cycles, then go to START. `ch_sel` is held constant from here through HOLD.
- START: `cnvst`=1 for exactly CNV_PULSE cycles, then go to CONV.
- CONV:
  - `eoc` is registered as eoc_q. Capture happens on the rising edge, eoc=1 and eoc_q=0.
  - On capture: res_data←sar, res_ch←ch_sel, res_err←0, go to HOLD.
  - An `eoc` level left high from a previous conversion is ignored. Only a fresh edge counts.
  - Timeout counter starts at 0 on CONV entry. If it reaches TIMEOUT-1 with no edge: res_data←0, res_err←1, go to HOLD.
- HOLD:
  - res_valid=1; res_data, res_ch and res_err are stable until handshake.
  - On res_valid & res_ready: `last_ch`←res_ch.
  - If en=1 and ch_mask≠0, go directly to SETTLE with the next channel; otherwise go to IDLE.
- en deasserted mid-sequence: the current conversion completes and is delivered, then the FSM returns to IDLE.
- ch_mask is sampled only when the next channel is picked. Changes mid-conversion do not abort it.
- Single enabled channel: it is re-converted back-to-back.
- `eoc` edge arriving outside CONV is ignored and logs nothing.

## Timing
- Reset values: ch_sel=0, cnvst=0, res_valid=0, res_data=0, res_ch=0, res_err=0, busy=0, state=IDLE, last_ch=NCH-1.
- rst=1 at any point, mid-conversion included: all of the above take effect at the next clk edge, and `cnvst` drops that edge.
- Start latency: en sampled high in IDLE at edge t0.
  - SETTLE covers edges t0+1 … t0+SETTLE, with `ch_sel` valid from t0+1.
  - `cnvst` is high for edges t0+SETTLE+1 … t0+SETTLE+CNV_PULSE.
- Capture latency: an `eoc` rising edge seen at edge k gives res_valid=1 from k+1, with res_data equal to `sar` at k.
- Handshake: transfer happens on the edge where res_valid & res_ready. res_valid drops at the next edge unless SETTLE was entered (res_valid is 0 in SETTLE).
- Back-to-back throughput: SETTLE + CNV_PULSE + conversion time + 1 cycles per sample with res_ready held high.
- All outputs are registered. No combinational path from an input to any output.

## Structure
- Package `sar_ctrl_pkg`:
  - state enum `sar_ctrl_state_t`
  - default constants: SAR_DW=8, SAR_SETTLE, SAR_CNV_PULSE, SAR_TIMEOUT
- Sub-module `sar_rr_pick`, combinational:
  - inputs ch_mask, last_ch
  - outputs next_ch and any
  - handles the wrap-around search

## Test plan
- Reset, en=1, ch_mask=4'b0101, with an `sar_logic` model that returns sar=8'hA0+ch after 8 cycles → conversions on ch0, 2, 0, 2. Check `cnvst` width 2, ch_sel stable through CONV, and res_data 8'hA0 / 8'hA2 alternating with matching res_ch.
- res_ready held low 20 cycles in HOLD → res_valid, res_data and res_ch are stable and no new `cnvst` is issued. res_ready=1 → exactly one transfer.
- `eoc` never asserted → res_valid after TIMEOUT cycles in CONV, with res_err=1 and res_data=0. The next conversion still starts normally.
- `eoc` held high from before `cnvst` and then pulsed → capture only on the new rising edge.
- rst=1 during START → `cnvst`=0 and all outputs at reset values at the next edge. The first conversion after release is ch0-lowest-enabled.
- en dropped during CONV, or ch_mask=0 → the current result is delivered, then the FSM goes to IDLE with busy=0 and no further `cnvst`.

Source files
------------

// File: rtl/sar_ctrl_pkg.sv
// Shared types and default timing constants for the SAR scan sequencer.
// Imported by the sequencer top and its round-robin channel picker.
package sar_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_START,
    S_CONV,
    S_HOLD
  } sar_ctrl_state_t;

  localparam int SAR_DW        = 8;
  localparam int SAR_SETTLE    = 4;
  localparam int SAR_CNV_PULSE = 2;
  localparam int SAR_TIMEOUT   = 64;

  function automatic int cnt_max(int a, int b, int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sar_rr_pick.sv
// Round-robin channel picker: first set mask bit strictly after last_ch,
// wrapping around to bit 0.
module sar_rr_pick
  import sar_ctrl_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic [NCH-1:0] ch_mask,
  input  logic [CHW-1:0] last_ch,
  output logic [CHW-1:0] next_ch,
  output logic           any
);

  logic           found;
  logic [CHW-1:0] idx;

  assign any = |ch_mask;

  always_comb begin
    next_ch = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx = CHW'((int'(last_ch) + i) % NCH);
      if (!found && ch_mask[idx]) begin
        next_ch = idx;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sar_scan_ctrl.sv
// Conversion sequencer for the 8-bit SAR core: round-robin channel scan,
// settle, start pulse, edge-qualified capture with timeout, valid/ready out.
module sar_scan_ctrl
  import sar_ctrl_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int CHW       = 2,
  parameter int DW        = SAR_DW,
  parameter int SETTLE    = SAR_SETTLE,
  parameter int CNV_PULSE = SAR_CNV_PULSE,
  parameter int TIMEOUT   = SAR_TIMEOUT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [NCH-1:0] ch_mask,
  output logic [CHW-1:0] ch_sel,
  output logic           cnvst,
  input  logic           eoc,
  input  logic [DW-1:0]  sar,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [DW-1:0]  res_data,
  output logic [CHW-1:0] res_ch,
  output logic           res_err,
  output logic           busy
);

  localparam int CW = $clog2(cnt_max(SETTLE, CNV_PULSE, TIMEOUT));

  sar_ctrl_state_t state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CHW-1:0]  ch_sel_q, ch_sel_d;
  logic [CHW-1:0]  last_ch_q, last_ch_d;
  logic [CHW-1:0]  res_ch_q, res_ch_d;
  logic [DW-1:0]   res_data_q, res_data_d;
  logic            res_err_q, res_err_d;
  logic            eoc_q;
  logic [CHW-1:0]  pick_last, next_ch;
  logic            any_ch, eoc_rise;

  // In HOLD the result being handed off becomes last_ch on this same edge.
  assign pick_last = (state_q == S_HOLD) ? res_ch_q : last_ch_q;
  assign eoc_rise  = eoc & ~eoc_q;

  sar_rr_pick #(
    .NCH(NCH),
    .CHW(CHW)
  ) u_pick (
    .ch_mask(ch_mask),
    .last_ch(pick_last),
    .next_ch(next_ch),
    .any    (any_ch)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ch_sel_d   = ch_sel_q;
    last_ch_d  = last_ch_q;
    res_ch_d   = res_ch_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (en && any_ch) begin
          state_d  = S_SETTLE;
          ch_sel_d = next_ch;
          cnt_d    = '0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CW'(SETTLE - 1)) begin
          state_d = S_START;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_START: begin
        if (cnt_q == CW'(CNV_PULSE - 1)) begin
          state_d = S_CONV;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CONV: begin
        if (eoc_rise) begin
          state_d    = S_HOLD;
          res_data_d = sar;
          res_ch_d   = ch_sel_q;
          res_err_d  = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d    = S_HOLD;
          res_data_d = '0;
          res_ch_d   = ch_sel_q;
          res_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          last_ch_d = res_ch_q;
          if (en && any_ch) begin
            state_d  = S_SETTLE;
            ch_sel_d = next_ch;
            cnt_d    = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ch_sel_q   <= '0;
      last_ch_q  <= CHW'(NCH - 1);
      res_ch_q   <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      eoc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ch_sel_q   <= ch_sel_d;
      last_ch_q  <= last_ch_d;
      res_ch_q   <= res_ch_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      eoc_q      <= eoc;
    end
  end

  assign ch_sel    = ch_sel_q;
  assign cnvst     = (state_q == S_START);
  assign res_valid = (state_q == S_HOLD);
  assign busy      = (state_q != S_IDLE);
  assign res_data  = res_data_q;
  assign res_ch    = res_ch_q;
  assign res_err   = res_err_q;

endmodule
